// File: rtl/route_table_lookup.sv
// ----------------------------------------------------------------------------
// route_table_lookup
//
// This is a writable routing table for the NoC router, with several
// independent lookup channels. Each channel presents a destination node ID.
// One clock later it gets back the output-port index and a miss flag from a
// registered response stage. That stage uses valid/ready handshaking.
//
// The table is programmed through a single config write port. Writes have no
// backpressure. A write to an address >= ENTRIES is ignored. A lookup of an
// out-of-range or never-written destination reports miss=1 and returns
// DEFAULT_PORT.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset (clears the table and drops
//                   any pending responses)
//   cfg_we     in   table write strobe
//   cfg_addr   in   [ADDR_W]            entry to write
//   cfg_port   in   [PORT_W]            port value to write
//   req_valid  in   [CHANNELS]          per-channel lookup request valid
//   req_ready  out  [CHANNELS]          per-channel request accept
//                                       (combinational from rsp_ready)
//   req_dst    in   [CHANNELS*ADDR_W]   destination ID, channel c at
//                                       [c*ADDR_W +: ADDR_W]
//   rsp_valid  out  [CHANNELS]          per-channel response valid
//   rsp_ready  in   [CHANNELS]          per-channel response accept
//   rsp_port   out  [CHANNELS*PORT_W]   looked-up port, channel c at
//                                       [c*PORT_W +: PORT_W]
//   rsp_miss   out  [CHANNELS]          1 = destination out of range or
//                                       entry never written
// ----------------------------------------------------------------------------
module route_table_lookup #(
    parameter int ENTRIES      = 1000,
    parameter int ADDR_W       = 10,
    parameter int PORT_W       = 3,
    parameter int CHANNELS     = 4,
    parameter int DEFAULT_PORT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [ADDR_W-1:0]          cfg_addr,
    input  logic [PORT_W-1:0]          cfg_port,
    input  logic [CHANNELS-1:0]        req_valid,
    output logic [CHANNELS-1:0]        req_ready,
    input  logic [CHANNELS*ADDR_W-1:0] req_dst,
    output logic [CHANNELS-1:0]        rsp_valid,
    input  logic [CHANNELS-1:0]        rsp_ready,
    output logic [CHANNELS*PORT_W-1:0] rsp_port,
    output logic [CHANNELS-1:0]        rsp_miss
);

    localparam logic [PORT_W-1:0] DEF_PORT   = PORT_W'(DEFAULT_PORT);
    // One extra bit so ENTRIES == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   ENTRIES_LIM = (ADDR_W+1)'(ENTRIES);

    // Table storage
    logic [PORT_W-1:0]   r_port_tbl [ENTRIES];
    logic [ENTRIES-1:0]  r_entry_vld;

    // Response stage
    logic [CHANNELS-1:0]             r_rsp_valid;
    logic [CHANNELS-1:0][PORT_W-1:0] r_rsp_port;
    logic [CHANNELS-1:0]             r_rsp_miss;

    // Per-channel lookup wires
    logic                            w_cfg_hit;
    logic [CHANNELS-1:0]             w_req_ready;
    logic [CHANNELS-1:0]             w_accept;
    logic [CHANNELS-1:0][ADDR_W-1:0] w_dst;
    logic [CHANNELS-1:0][PORT_W-1:0] w_lk_port;
    logic [CHANNELS-1:0]             w_lk_miss;

    // A config write only takes effect when its address is inside the table.
    assign w_cfg_hit = cfg_we && ({1'b0, cfg_addr} < ENTRIES_LIM);

    // The response slot is free when empty or when it drains this cycle.
    // Reset holds ready low so nothing is accepted while rst is high.
    assign w_req_ready = (~r_rsp_valid | rsp_ready) & {CHANNELS{~rst}};
    assign w_accept    = req_valid & w_req_ready;

    // Table write / clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_port_tbl[i] <= DEF_PORT;
            end
            r_entry_vld <= '0;
        end else if (w_cfg_hit) begin
            r_port_tbl[cfg_addr]  <= cfg_port;
            r_entry_vld[cfg_addr] <= 1'b1;
        end
    end

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_ch
            logic w_in_range;
            logic w_bypass;

            assign w_dst[c]   = req_dst[c*ADDR_W +: ADDR_W];
            assign w_in_range = ({1'b0, w_dst[c]} < ENTRIES_LIM);
            // Same-edge write to the looked-up entry wins over stored state.
            assign w_bypass   = w_cfg_hit && (cfg_addr == w_dst[c]);

            // Lookup result for this channel
            always_comb begin
                w_lk_port[c] = DEF_PORT;
                w_lk_miss[c] = 1'b1;
                if (w_bypass) begin
                    w_lk_port[c] = cfg_port;
                    w_lk_miss[c] = 1'b0;
                end else if (w_in_range && r_entry_vld[w_dst[c]]) begin
                    w_lk_port[c] = r_port_tbl[w_dst[c]];
                    w_lk_miss[c] = 1'b0;
                end else begin
                    w_lk_port[c] = DEF_PORT;
                    w_lk_miss[c] = 1'b1;
                end
            end

            // Response register. Port and miss hold once the response is
            // consumed, so only the valid bit falls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rsp_valid[c] <= 1'b0;
                    r_rsp_port[c]  <= DEF_PORT;
                    r_rsp_miss[c]  <= 1'b0;
                end else if (w_accept[c]) begin
                    r_rsp_valid[c] <= 1'b1;
                    r_rsp_port[c]  <= w_lk_port[c];
                    r_rsp_miss[c]  <= w_lk_miss[c];
                end else if (r_rsp_valid[c] && rsp_ready[c]) begin
                    r_rsp_valid[c] <= 1'b0;
                end
            end
        end
    endgenerate

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_port  = r_rsp_port;
    assign rsp_miss  = r_rsp_miss;

endmodule

// File: tb/tb_route_table_lookup.sv
// ----------------------------------------------------------------------------
// tb_route_table_lookup
//
// Directed-vector bench for route_table_lookup. Inputs are driven 1 ns after
// each rising edge, and outputs are sampled at that same point. Every
// expected value below is a hand-computed constant.
// ----------------------------------------------------------------------------
module tb_route_table_lookup;

    localparam int ENTRIES  = 1000;
    localparam int ADDR_W   = 10;
    localparam int PORT_W   = 3;
    localparam int CHANNELS = 4;

    logic                       clk;
    logic                       rst;
    logic                       cfg_we;
    logic [ADDR_W-1:0]          cfg_addr;
    logic [PORT_W-1:0]          cfg_port;
    logic [CHANNELS-1:0]        req_valid;
    logic [CHANNELS-1:0]        req_ready;
    logic [CHANNELS*ADDR_W-1:0] req_dst;
    logic [CHANNELS-1:0]        rsp_valid;
    logic [CHANNELS-1:0]        rsp_ready;
    logic [CHANNELS*PORT_W-1:0] rsp_port;
    logic [CHANNELS-1:0]        rsp_miss;

    int n_checks;
    int n_errors;

    route_table_lookup #(
        .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .PORT_W(PORT_W),
        .CHANNELS(CHANNELS), .DEFAULT_PORT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_port(cfg_port),
        .req_valid(req_valid), .req_ready(req_ready), .req_dst(req_dst),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_port(rsp_port), .rsp_miss(rsp_miss)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dst(input int ch, input int dst);
        req_dst[ch*ADDR_W +: ADDR_W] = ADDR_W'(dst);
    endtask

    function automatic logic [31:0] port_of(input int ch);
        return 32'(rsp_port[ch*PORT_W +: PORT_W]);
    endfunction

    task automatic cfg_write(input int addr, input int port);
        cfg_we   = 1'b1;
        cfg_addr = ADDR_W'(addr);
        cfg_port = PORT_W'(port);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_port  = '0;
        req_valid = '0;
        req_dst   = '0;
        rsp_ready = 4'hF;
        tick();
        tick();

        // Reset state; ready forced low while rst is high
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_rsp_port",  32'(rsp_port),  32'h0);
        check_eq("rst_rsp_miss",  32'(rsp_miss),  32'h0);
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(req_ready), 32'hF);

        // Lookup of an unwritten entry
        set_dst(0, 5);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        check_eq("t1_valid", 32'(rsp_valid), 32'h1);
        check_eq("t1_miss0", 32'(rsp_miss[0]), 32'h1);
        check_eq("t1_port0", port_of(0), 32'h0);
        tick();
        check_eq("t1_drain", 32'(rsp_valid), 32'h0);

        // Write 5=3, then look up 5 on ch0 and unwritten 999 on ch1
        cfg_write(5, 3);
        tick();
        cfg_we = 1'b0;
        set_dst(0, 5);
        set_dst(1, 999);
        req_valid = 4'b0011;
        tick();
        req_valid = 4'b0000;
        check_eq("t2_valid", 32'(rsp_valid), 32'h3);
        check_eq("t2_port0", port_of(0), 32'h3);
        check_eq("t2_miss0", 32'(rsp_miss[0]), 32'h0);
        check_eq("t2_miss1", 32'(rsp_miss[1]), 32'h1);
        check_eq("t2_port1", port_of(1), 32'h0);
        tick();
        check_eq("t2_drain", 32'(rsp_valid), 32'h0);
        check_eq("t2_hold_port0", port_of(0), 32'h3);

        // Same-edge write/lookup collision on addr 7
        cfg_write(7, 6);
        set_dst(2, 7);
        req_valid = 4'b0100;
        tick();
        cfg_we    = 1'b0;
        req_valid = 4'b0000;
        check_eq("t3_valid2", 32'(rsp_valid[2]), 32'h1);
        check_eq("t3_port2",  port_of(2), 32'h6);
        check_eq("t3_miss2",  32'(rsp_miss[2]), 32'h0);
        tick();

        // Out-of-range lookups
        set_dst(3, 1000);
        req_valid = 4'b1000;
        tick();
        check_eq("t4_miss_1000", 32'(rsp_miss[3]), 32'h1);
        check_eq("t4_port_1000", port_of(3), 32'h0);
        set_dst(3, 1023);
        tick();
        req_valid = 4'b0000;
        check_eq("t4_miss_1023", 32'(rsp_miss[3]), 32'h1);
        check_eq("t4_port_1023", port_of(3), 32'h0);
        tick();

        // Out-of-range write is ignored: existing entries intact, 10 untouched
        cfg_write(1010, 5);
        tick();
        cfg_we = 1'b0;
        set_dst(0, 5);
        set_dst(1, 10);
        set_dst(2, 7);
        set_dst(3, 1010);
        req_valid = 4'b1111;
        tick();
        req_valid = 4'b0000;
        check_eq("t4_oor_port0", port_of(0), 32'h3);
        check_eq("t4_oor_port2", port_of(2), 32'h6);
        check_eq("t4_oor_miss",  32'(rsp_miss), 32'hA);
        check_eq("t4_oor_port3", port_of(3), 32'h0);
        tick();

        // Several channels looking up the same entry
        set_dst(0, 7);
        set_dst(1, 7);
        set_dst(2, 7);
        set_dst(3, 7);
        req_valid = 4'b1111;
        tick();
        req_valid = 4'b0000;
        check_eq("t5_same_dst_port", 32'(rsp_port), 32'(12'o6666));
        check_eq("t5_same_dst_miss", 32'(rsp_miss), 32'h0);
        tick();

        // Backpressure on ch1
        rsp_ready = 4'b1101;
        set_dst(1, 5);
        req_valid = 4'b0010;
        tick();
        set_dst(1, 7);
        for (int i = 0; i < 5; i++) begin
            check_eq("t6_stall_ready", 32'(req_ready[1]), 32'h0);
            check_eq("t6_stall_valid", 32'(rsp_valid[1]), 32'h1);
            check_eq("t6_stall_port",  port_of(1), 32'h3);
            tick();
        end
        rsp_ready = 4'b1111;
        #1;
        check_eq("t6_ready_feedthru", 32'(req_ready[1]), 32'h1);
        tick();
        req_valid = 4'b0000;
        check_eq("t6_new_valid", 32'(rsp_valid[1]), 32'h1);
        check_eq("t6_new_port",  port_of(1), 32'h6);
        tick();
        check_eq("t6_drain", 32'(rsp_valid[1]), 32'h0);

        // Back-to-back streaming on all channels, then reset mid-stream
        set_dst(0, 5);
        set_dst(1, 7);
        set_dst(2, 5);
        set_dst(3, 7);
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t7_stream_valid", 32'(rsp_valid), 32'hF);
            check_eq("t7_stream_port",  32'(rsp_port), 32'(12'o6363));
        end
        rst = 1'b1;
        #1;
        check_eq("t7_rst_ready", 32'(req_ready), 32'h0);
        tick();
        check_eq("t7_rst_valid", 32'(rsp_valid), 32'h0);
        rst = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        check_eq("t7_after_rst_valid", 32'(rsp_valid[0]), 32'h1);
        check_eq("t7_after_rst_miss",  32'(rsp_miss[0]), 32'h1);
        check_eq("t7_after_rst_port",  port_of(0), 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
